// File: rtl/decade_chain_ctrl.sv
// Four-digit BCD up-counter with run/pause/clear control, prescaled tick and terminal-count target.
// All outputs registered: a tick shows on count one cycle after the prescaler's last cycle; no backpressure.
module decade_chain_ctrl #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic [15:0] target,
  output logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_t      state_q;
  logic [15:0] count_q;
  logic [15:0] presc_q;
  logic [15:0] tgt_q;
  logic        busy_q;
  logic        done_q;
  logic        wrap_q;

  logic [15:0] count_d;
  logic [15:0] presc_d;
  logic        inc_carry;
  logic        tgt_valid;
  logic        tick;
  logic        hit;
  logic        start_cmd;

  // Ripple a decimal carry from the least significant digit upward.
  always_comb begin
    count_d   = count_q;
    inc_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_carry) begin
        if (count_q[4*i +: 4] >= 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
    end
  end

  // A target holding any non-decimal digit can never be reached.
  always_comb begin
    tgt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (tgt_q[4*i +: 4] > 4'd9) begin
        tgt_valid = 1'b0;
      end
    end
  end

  assign presc_d   = presc_q + 16'd1;
  assign tick      = (state_q == RUN) && (presc_q == PRESC_LAST);
  assign hit       = tgt_valid && (count_d == tgt_q);
  assign start_cmd = start && !stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      presc_q <= '0;
      tgt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear) begin
        state_q <= IDLE;
        count_q <= '0;
        presc_q <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_cmd) begin
              tgt_q   <= target;
              presc_q <= '0;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state_q <= PAUSE;
              busy_q  <= 1'b0;
            end else if (tick) begin
              presc_q <= '0;
              count_q <= count_d;
              wrap_q  <= inc_carry;
              if (hit) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              presc_q <= presc_d;
            end
          end
          PAUSE: begin
            if (start_cmd) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          DONE: begin
            if (start_cmd) begin
              count_q <= '0;
              presc_q <= '0;
              tgt_q   <= target;
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Scoreboard bench: two counters (PRESCALE=2 and PRESCALE=1) driven by directed sequences;
// expected count/done/wrap events are queued by stimulus and popped by per-instance monitors.
module tb_decade_chain_ctrl;

  typedef struct packed {
    logic [15:0] count;
    logic        done;
    logic        wrap;
    logic        busy;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_start, a_stop, a_clear;
  logic [15:0] a_target;
  logic [15:0] a_count;
  logic        a_busy, a_done, a_wrap;
  logic        b_start, b_stop, b_clear;
  logic [15:0] b_target;
  logic [15:0] b_count;
  logic        b_busy, b_done, b_wrap;

  ev_t         a_q[$];
  ev_t         b_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [15:0] a_prev = '0;
  logic [15:0] b_prev = '0;

  always #5 clk = ~clk;

  decade_chain_ctrl #(.PRESCALE(2)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .stop(a_stop), .clear(a_clear),
    .target(a_target), .count(a_count), .busy(a_busy), .done(a_done), .wrap(a_wrap)
  );

  decade_chain_ctrl #(.PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .stop(b_stop), .clear(b_clear),
    .target(b_target), .count(b_count), .busy(b_busy), .done(b_done), .wrap(b_wrap)
  );

  function automatic ev_t mk_ev(input logic [15:0] c, input logic d, input logic w, input logic b);
    ev_t e;
    e.count = c;
    e.done  = d;
    e.wrap  = w;
    e.busy  = b;
    return e;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic ev_chk(input string name, input ev_t act, input ev_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got count=%h done=%b wrap=%b busy=%b, want count=%h done=%b wrap=%b busy=%b",
               name, act.count, act.done, act.wrap, act.busy, exp.count, exp.done, exp.wrap, exp.busy);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitors: an event is any count change or a done/wrap pulse.
  always @(negedge clk) begin
    if (mon_en && (a_count !== a_prev || a_done || a_wrap)) begin
      if (a_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_event: got count=%h done=%b wrap=%b, want no event", a_count, a_done, a_wrap);
      end else begin
        ev_chk("a_event", mk_ev(a_count, a_done, a_wrap, a_busy), a_q.pop_front());
      end
    end
    a_prev = a_count;
  end

  always @(negedge clk) begin
    if (mon_en && (b_count !== b_prev || b_done || b_wrap)) begin
      if (b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_event: got count=%h done=%b wrap=%b, want no event", b_count, b_done, b_wrap);
      end else begin
        ev_chk("b_event", mk_ev(b_count, b_done, b_wrap, b_busy), b_q.pop_front());
      end
    end
    b_prev = b_count;
  end

  initial begin
    rst = 1'b0;
    a_start = 1'b0; a_stop = 1'b0; a_clear = 1'b0; a_target = '0;
    b_start = 1'b0; b_stop = 1'b0; b_clear = 1'b0; b_target = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_a_count", a_count, 16'h0000);
    chk("rst_a_busy", 16'(a_busy), 16'd0);
    chk("rst_a_done", 16'(a_done), 16'd0);
    chk("rst_a_wrap", 16'(a_wrap), 16'd0);
    chk("rst_b_count", b_count, 16'h0000);
    chk("rst_b_busy", 16'(b_busy), 16'd0);
    chk("rst_b_done", 16'(b_done), 16'd0);
    chk("rst_b_wrap", 16'(b_wrap), 16'd0);
    cyc(2);
    rst = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // PRESCALE=2, target 0003: ticks land on cycles 3, 5, 7.
    a_q.push_back(mk_ev(16'h0001, 1'b0, 1'b0, 1'b1));
    a_q.push_back(mk_ev(16'h0002, 1'b0, 1'b0, 1'b1));
    a_q.push_back(mk_ev(16'h0003, 1'b1, 1'b0, 1'b0));
    a_target = 16'h0003;
    a_start  = 1'b1;
    cyc(1);
    a_start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("p2_count", a_count, (c < 3) ? 16'h0000 : (c < 5) ? 16'h0001 : (c < 7) ? 16'h0002 : 16'h0003);
      chk("p2_busy", 16'(a_busy), (c < 7) ? 16'd1 : 16'd0);
      chk("p2_done", 16'(a_done), (c == 7) ? 16'd1 : 16'd0);
    end

    // Restart from DONE, stop on a tick cycle at 0005, hold, resume, then clear over a tick.
    a_q.push_back(mk_ev(16'h0000, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 6; k++) a_q.push_back(mk_ev(to_bcd(k), 1'b0, 1'b0, 1'b1));
    a_q.push_back(mk_ev(16'h0000, 1'b0, 1'b0, 1'b0));
    cyc(1);
    a_target = 16'h0100;
    a_start  = 1'b1;
    cyc(1);
    a_start = 1'b0;
    cyc(11);
    a_stop = 1'b1;
    cyc(1);
    a_stop = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("pause_hold_count", a_count, 16'h0005);
    end
    chk("pause_busy", 16'(a_busy), 16'd0);
    cyc(1);
    a_start = 1'b1;
    cyc(1);
    a_start = 1'b0;
    @(negedge clk);
    chk("resume_count", a_count, 16'h0005);
    chk("resume_busy", 16'(a_busy), 16'd1);
    @(negedge clk);
    chk("resume_tick_count", a_count, 16'h0006);
    cyc(1);
    a_clear = 1'b1;
    cyc(1);
    a_clear = 1'b0;
    @(negedge clk);
    chk("clear_count", a_count, 16'h0000);
    chk("clear_busy", 16'(a_busy), 16'd0);

    // PRESCALE=1: preload 0099 by run/pause, resume with a new target input that must be ignored.
    for (int k = 1; k <= 99; k++) b_q.push_back(mk_ev(to_bcd(k), 1'b0, 1'b0, 1'b1));
    b_q.push_back(mk_ev(16'h0100, 1'b1, 1'b0, 1'b0));
    cyc(1);
    b_target = 16'h0100;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    cyc(99);
    b_stop = 1'b1;
    cyc(1);
    b_stop = 1'b0;
    @(negedge clk);
    chk("preload_count", b_count, 16'h0099);
    chk("preload_busy", 16'(b_busy), 16'd0);
    cyc(1);
    b_target = 16'h0200;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    @(negedge clk);
    chk("carry_pre_count", b_count, 16'h0099);
    @(negedge clk);
    chk("carry_count", b_count, 16'h0100);
    chk("carry_done", 16'(b_done), 16'd1);
    chk("carry_busy", 16'(b_busy), 16'd0);
    @(negedge clk);
    chk("carry_done_pulse", 16'(b_done), 16'd0);

    // start+stop+clear together at 0042 while the next tick would reach the target.
    b_q.push_back(mk_ev(16'h0000, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 42; k++) b_q.push_back(mk_ev(to_bcd(k), 1'b0, 1'b0, 1'b1));
    b_q.push_back(mk_ev(16'h0000, 1'b0, 1'b0, 1'b0));
    cyc(1);
    b_target = 16'h0043;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    cyc(42);
    b_start = 1'b1; b_stop = 1'b1; b_clear = 1'b1;
    @(negedge clk);
    chk("cmd_pre_count", b_count, 16'h0042);
    cyc(1);
    b_start = 1'b0; b_stop = 1'b0; b_clear = 1'b0;
    @(negedge clk);
    chk("cmd_count", b_count, 16'h0000);
    chk("cmd_busy", 16'(b_busy), 16'd0);
    chk("cmd_done", 16'(b_done), 16'd0);
    @(negedge clk);
    chk("cmd_done_after", 16'(b_done), 16'd0);

    // Target 0000 matches only on the 9999 rollover.
    for (int k = 1; k <= 9999; k++) b_q.push_back(mk_ev(to_bcd(k), 1'b0, 1'b0, 1'b1));
    b_q.push_back(mk_ev(16'h0000, 1'b1, 1'b1, 1'b0));
    cyc(1);
    b_target = 16'h0000;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    cyc(9998);
    b_stop = 1'b1;
    cyc(1);
    b_stop = 1'b0;
    @(negedge clk);
    chk("roll_pre_count", b_count, 16'h9998);
    cyc(1);
    b_target = 16'h1234;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    @(negedge clk);
    chk("roll_resume_count", b_count, 16'h9998);
    @(negedge clk);
    chk("roll_9999_count", b_count, 16'h9999);
    chk("roll_9999_wrap", 16'(b_wrap), 16'd0);
    @(negedge clk);
    chk("roll_count", b_count, 16'h0000);
    chk("roll_wrap", 16'(b_wrap), 16'd1);
    chk("roll_done", 16'(b_done), 16'd1);
    chk("roll_busy", 16'(b_busy), 16'd0);
    @(negedge clk);
    chk("roll_wrap_pulse", 16'(b_wrap), 16'd0);
    chk("roll_done_pulse", 16'(b_done), 16'd0);

    // Reset pulse between clock edges while running.
    for (int k = 1; k <= 123; k++) b_q.push_back(mk_ev(to_bcd(k), 1'b0, 1'b0, 1'b1));
    cyc(1);
    b_target = 16'h00A0;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    cyc(123);
    @(negedge clk);
    chk("arst_pre_count", b_count, 16'h0123);
    chk("arst_pre_busy", 16'(b_busy), 16'd1);
    b_q.push_back(mk_ev(16'h0000, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    chk("arst_count", b_count, 16'h0000);
    chk("arst_busy", 16'(b_busy), 16'd0);
    #1 rst = 1'b0;
    cyc(5);
    @(negedge clk);
    chk("arst_idle_count", b_count, 16'h0000);
    chk("arst_idle_busy", 16'(b_busy), 16'd0);

    // Non-decimal target never matches; wrap pulses every 10000 ticks.
    for (int k = 1; k <= 20001; k++)
      b_q.push_back(mk_ev(to_bcd(k % 10000), 1'b0, (k % 10000) == 0, 1'b1));
    cyc(1);
    b_target = 16'h00A0;
    b_start  = 1'b1;
    cyc(1);
    b_start = 1'b0;
    cyc(9999);
    @(negedge clk);
    chk("wrap1_pre_count", b_count, 16'h9999);
    @(negedge clk);
    chk("wrap1_count", b_count, 16'h0000);
    chk("wrap1_wrap", 16'(b_wrap), 16'd1);
    chk("wrap1_busy", 16'(b_busy), 16'd1);
    repeat (9999) @(negedge clk);
    chk("wrap2_pre_count", b_count, 16'h9999);
    @(negedge clk);
    chk("wrap2_wrap", 16'(b_wrap), 16'd1);
    chk("wrap2_done", 16'(b_done), 16'd0);
    cyc(1);
    b_stop = 1'b1;
    cyc(1);
    b_stop = 1'b0;
    @(negedge clk);
    chk("final_count", b_count, 16'h0001);
    chk("final_busy", 16'(b_busy), 16'd0);

    for (int i = 0; i < 20 && (a_q.size() != 0 || b_q.size() != 0); i++) @(negedge clk);
    chk("a_queue_drained", 16'(a_q.size()), 16'd0);
    chk("b_queue_drained", 16'(b_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decade_chain_ctrl.md
DECADE_CHAIN_CTRL -- requirements
Module: decade_chain_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 10: clock cycles per count tick; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin or resume counting (level sampled each cycle).
REQ-005 SHALL have port stop, input, 1 bit: pause counting.
REQ-006 SHALL have port clear, input, 1 bit: abort, return to idle and zero the count.
REQ-007 SHALL have port target, input, 16 bits: terminal value as 4 BCD digits, [15:12] most significant.
REQ-008 SHALL have port count, output, 16 bits: current 4-digit BCD count, registered.
REQ-009 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when the count reaches the latched target.
REQ-011 SHALL have port wrap, output, 1 bit: one-cycle pulse when count rolls from 9999 to 0000.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-013 SHALL apply command priority clear > stop > start when commands coincide in the same cycle.
REQ-014 SHALL, on clear in any state, go to IDLE, set count=0000 and prescaler=0, and suppress done and wrap in that cycle.
REQ-015 SHALL, on start in IDLE, latch target, set prescaler=0 and go to RUN; count keeps its value (0000 after reset or clear).
REQ-016 SHALL, on start in PAUSE, go to RUN with count and prescaler unchanged; target is not re-latched.
REQ-017 SHALL, on start in DONE, set count=0000 and prescaler=0, latch target and go to RUN.
REQ-018 SHALL ignore start in RUN.
REQ-019 SHALL, on stop in RUN, go to PAUSE and freeze count and prescaler; stop is ignored in IDLE, PAUSE and DONE.
REQ-020 SHALL, in RUN only, increment prescaler 0..PRESCALE-1; in the cycle it equals PRESCALE-1 a tick occurs and prescaler returns to 0.
REQ-021 SHALL, on tick, BCD-increment count: digit 0 +1; a digit at 9 becomes 0 and carries to the next digit; no digit ever holds a value greater than 9.
REQ-022 SHALL, on a tick with count=9999, set count=0000 and pulse wrap for one cycle, aligned with count showing 0000.
REQ-023 SHALL compare the post-increment value with the latched target; on match, go to DONE and pulse done for one cycle, aligned with count showing the target.
REQ-024 SHALL never match a latched target containing any digit greater than 9; counting then continues and wraps indefinitely.
REQ-025 SHALL match a latched target of 0000 only on the 9999->0000 rollover; in that cycle wrap and done pulse together.
REQ-026 SHALL, in DONE, hold count and keep busy low.
REQ-027 SHALL make the first tick occur PRESCALE cycles after busy rises; with PRESCALE=1, count increments every RUN cycle.
REQ-028 SHALL let a stop coinciding with a tick cycle take priority: no increment, go to PAUSE.

Reset
REQ-029 SHALL, while rst=1, asynchronously force state=IDLE, count=0000, prescaler=0, latched target=0000, and busy, done and wrap low.
REQ-030 SHALL, after rst deasserts mid-RUN, resume in IDLE and require a new start.

Verification
REQ-031 SHALL cover: PRESCALE=2, target=0003, start pulse at cycle 0 -> busy=1 at cycle 1; count 0001, 0002, 0003 at cycles 3, 5, 7; done pulse at cycle 7; busy=0 from cycle 7.
REQ-032 SHALL cover: PRESCALE=1, count preloaded to 0099 via run/pause, target=0100 -> next tick gives 0100 with done=1 (carry across two digits).
REQ-033 SHALL cover: PRESCALE=1, target=0000, run from 9998 -> 9999, then 0000 with wrap=1 and done=1 in the same cycle.
REQ-034 SHALL cover: start, stop and clear asserted in the same cycle while in RUN at count 0042 -> IDLE, count=0000, busy=0, no done.
REQ-035 SHALL cover: stop at count 0005 -> count held at 0005 for 20 cycles; start -> next tick gives 0006 after the remaining prescale cycles.
REQ-036 SHALL cover: rst pulse asserted between clock edges during RUN -> count=0000 and busy=0 immediately, without waiting for a clock edge; target=00A0 -> never done, wrap pulses every 10000 ticks.
